// File: rtl/sr_result_buffer.sv
`default_nettype none
// ============================================================================
// Module   : sr_result_buffer
// Purpose  : Two-entry elastic buffer placed after the shift/rotate execute
//            unit. It holds {result, flags, destination tag, flag_we} per
//            entry and presents the entries in order to writeback through a
//            valid/ready handshake. The architectural flag register
//            {CF, ZF, SF, OF} is updated only when an entry retires with
//            flag_we set. A flush discards every buffered entry. The entry
//            that retires in the flush cycle still updates the flags.
//
// Ports    : clk           rising-edge clock
//            rst_n         synchronous active-low reset
//            i_in_valid    upstream result valid
//            o_in_ready    buffer can accept an entry this cycle
//            i_in_res      shift/rotate result
//            i_in_flags    {CF, ZF, SF, OF} produced with the result
//            i_in_rd       destination register tag
//            i_in_flag_we  entry updates architectural flags on retire
//            i_flush       discard buffered entries
//            o_out_valid   head entry valid
//            i_out_ready   writeback accepts the head entry
//            o_out_res     head result
//            o_out_rd      head destination tag
//            o_arch_flags  architectural {CF, ZF, SF, OF}
//            o_occupancy   number of entries held (0..2)
//
// Revision : 1.0 - initial release
// ============================================================================
module sr_result_buffer #(
    parameter int DATA_W = 8,
    parameter int RD_W   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [DATA_W-1:0] i_in_res,
    input  logic [3:0]        i_in_flags,
    input  logic [RD_W-1:0]   i_in_rd,
    input  logic              i_in_flag_we,
    input  logic              i_flush,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_out_res,
    output logic [RD_W-1:0]   o_out_rd,
    output logic [3:0]        o_arch_flags,
    output logic [1:0]        o_occupancy
);

    localparam logic [1:0] c_CNT_EMPTY = 2'd0;
    localparam logic [1:0] c_CNT_FULL  = 2'd2;

    // Entry storage. It is not reset, because an entry is only read while
    // the count says it is live.
    logic [DATA_W-1:0] r_res   [0:1];
    logic [3:0]        r_flags [0:1];
    logic [RD_W-1:0]   r_rd    [0:1];
    logic              r_we    [0:1];

    logic              r_head;
    logic              r_tail;
    logic [1:0]        r_count;
    logic [3:0]        r_arch_flags;

    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_push;
    logic              w_pop;

    // Readiness depends only on the count. This keeps out_ready from
    // reaching in_ready combinationally.
    assign w_in_ready  = (r_count != c_CNT_FULL);
    assign w_out_valid = (r_count != c_CNT_EMPTY);
    assign w_push      = i_in_valid & w_in_ready;
    assign w_pop       = w_out_valid & i_out_ready;

    // Storage write. A push in a flush cycle is dropped, so it is not written.
    always_ff @(posedge clk) begin
        if (rst_n && w_push && !i_flush) begin
            r_res[r_tail]   <= i_in_res;
            r_flags[r_tail] <= i_in_flags;
            r_rd[r_tail]    <= i_in_rd;
            r_we[r_tail]    <= i_in_flag_we;
        end
    end

    // Pointers and count. With two entries, a pointer wrap is a bit toggle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            r_count <= c_CNT_EMPTY;
        end else if (i_flush) begin
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            r_count <= c_CNT_EMPTY;
        end else begin
            if (w_push) begin
                r_tail <= ~r_tail;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Architectural flags. Writeback has already consumed a popped head
    // entry, so it retires even in a flush cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_arch_flags <= 4'b0000;
        end else if (w_pop && r_we[r_head]) begin
            r_arch_flags <= r_flags[r_head];
        end
    end

    assign o_in_ready   = w_in_ready;
    assign o_out_valid  = w_out_valid;
    assign o_out_res    = r_res[r_head];
    assign o_out_rd     = r_rd[r_head];
    assign o_arch_flags = r_arch_flags;
    assign o_occupancy  = r_count;

endmodule
`default_nettype wire

// File: tb/tb_sr_result_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sr_result_buffer
// Purpose  : Self-checking bench for sr_result_buffer. A queue-based model
//            predicts the buffer contents and the architectural flags. The
//            bench compares the model with the outputs every cycle during
//            directed and random stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sr_result_buffer;

    typedef struct packed {
        logic [7:0] res;
        logic [3:0] flags;
        logic [2:0] rd;
        logic       we;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_res;
    logic [3:0] in_flags;
    logic [2:0] in_rd;
    logic       in_flag_we;
    logic       flush;
    logic       out_ready;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_res;
    logic [2:0] out_rd;
    logic [3:0] arch_flags;
    logic [1:0] occupancy;

    int         n_assert = 0;
    int         n_fail   = 0;

    ent_t       q[$];
    logic [3:0] m_arch = 4'b0000;

    always #5 clk = ~clk;

    sr_result_buffer #(
        .DATA_W (8),
        .RD_W   (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_in_valid   (in_valid),
        .o_in_ready   (in_ready),
        .i_in_res     (in_res),
        .i_in_flags   (in_flags),
        .i_in_rd      (in_rd),
        .i_in_flag_we (in_flag_we),
        .i_flush      (flush),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
        .o_out_res    (out_res),
        .o_out_rd     (out_rd),
        .o_arch_flags (arch_flags),
        .o_occupancy  (occupancy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle. Drive the inputs, check the outputs at the falling
    // edge against the model, then advance the model at the rising edge.
    task automatic cyc(input logic rn, input logic v, input logic [7:0] r,
                       input logic [3:0] f, input logic [2:0] d, input logic we,
                       input logic fl, input logic ordy, input bit check);
        bit   push;
        bit   pop;
        ent_t e;
        rst_n      = rn;
        in_valid   = v;
        in_res     = r;
        in_flags   = f;
        in_rd      = d;
        in_flag_we = we;
        flush      = fl;
        out_ready  = ordy;
        @(negedge clk);
        if (check) begin
            chk("in_ready",   32'(in_ready),   32'(q.size() != 2));
            chk("out_valid",  32'(out_valid),  32'(q.size() != 0));
            chk("occupancy",  32'(occupancy),  32'(q.size()));
            chk("arch_flags", 32'(arch_flags), 32'(m_arch));
            if (q.size() != 0) begin
                chk("out_res", 32'(out_res), 32'(q[0].res));
                chk("out_rd",  32'(out_rd),  32'(q[0].rd));
            end
        end
        push = v && (q.size() != 2);
        pop  = ordy && (q.size() != 0);
        @(posedge clk);
        if (!rn) begin
            q.delete();
            m_arch = 4'b0000;
        end else begin
            if (pop) begin
                e = q.pop_front();
                if (e.we) m_arch = e.flags;
            end
            if (fl) q.delete();
            else if (push) q.push_back('{res: r, flags: f, rd: d, we: we});
        end
        #1;
    endtask

    task automatic idle(input logic ordy);
        cyc(1'b1, 1'b0, 8'h00, 4'h0, 3'd0, 1'b0, 1'b0, ordy, 1'b1);
    endtask

    task automatic put(input logic [7:0] r, input logic [3:0] f, input logic [2:0] d,
                       input logic we, input logic ordy);
        cyc(1'b1, 1'b1, r, f, d, we, 1'b0, ordy, 1'b1);
    endtask

    initial begin
        // Reset held for two cycles with in_valid high. The state is unknown
        // before the first edge, so the first cycle is not checked.
        cyc(1'b0, 1'b1, 8'h55, 4'hF, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 8'h55, 4'hF, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_arch",      32'(arch_flags), 32'h0);

        // Streaming with out_ready held high.
        put(8'h40, 4'b0000, 3'd3, 1'b1, 1'b1);
        put(8'h00, 4'b1100, 3'd5, 1'b1, 1'b1);
        chk("stream_arch0", 32'(arch_flags), 32'b0000);
        idle(1'b1);
        chk("stream_arch1", 32'(arch_flags), 32'b1100);
        idle(1'b1);

        // Backpressure. 0x33 is offered until the buffer accepts it.
        put(8'h11, 4'h0, 3'd1, 1'b0, 1'b0);
        put(8'h22, 4'h0, 3'd2, 1'b0, 1'b0);
        put(8'h33, 4'h0, 3'd3, 1'b0, 1'b0);
        chk("bp_occupancy", 32'(occupancy), 32'd2);
        chk("bp_in_ready",  32'(in_ready),  32'd0);
        put(8'h33, 4'h0, 3'd3, 1'b0, 1'b1);
        put(8'h33, 4'h0, 3'd3, 1'b0, 1'b1);
        chk("bp_tail", 32'(out_res), 32'h33);
        idle(1'b1);
        idle(1'b1);

        // flag_we masking.
        put(8'h01, 4'b0010, 3'd1, 1'b1, 1'b1);
        put(8'h02, 4'b1111, 3'd2, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);
        chk("we_mask_arch", 32'(arch_flags), 32'b0010);

        // Flush while full, with a retire and a push in the same cycle.
        put(8'hA0, 4'b1000, 3'd4, 1'b1, 1'b0);
        put(8'hB0, 4'b0100, 3'd5, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 8'hC0, 4'b0001, 3'd6, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("flush_arch",      32'(arch_flags), 32'b1000);
        chk("flush_occupancy", 32'(occupancy),  32'd0);
        chk("flush_out_valid", 32'(out_valid),  32'd0);
        idle(1'b1);
        idle(1'b1);

        // Mid-stream reset with two entries held.
        put(8'h5A, 4'b0001, 3'd7, 1'b1, 1'b1);
        idle(1'b1);
        chk("pre_rst_arch", 32'(arch_flags), 32'b0001);
        put(8'h61, 4'b1010, 3'd1, 1'b1, 1'b0);
        put(8'h62, 4'b0110, 3'd2, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 4'h0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("mrst_occupancy", 32'(occupancy),  32'd0);
        chk("mrst_arch",      32'(arch_flags), 32'h0);
        idle(1'b1);
        idle(1'b1);

        // Random traffic, including occasional flushes and resets.
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 49) != 0),
                1'($urandom_range(0, 1)),
                8'($urandom),
                4'($urandom),
                3'($urandom),
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 19) == 0),
                ($urandom_range(0, 3) != 0),
                1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sr_result_buffer.md
# sr_result_buffer

Two-entry elastic buffer and architectural flag register sitting directly downstream of the shift/rotate execute unit in the pipelined 8-bit processor. It captures each result byte, its 4-bit flag vector {CF, ZF, SF, OF} and its destination register tag, and presents them in order to the writeback stage through a valid/ready handshake. It commits flags to the architectural flag register only when an entry retires, and supports a pipeline flush that discards in-flight entries.

## Interface
- DATA_W, default 8: result width.
- RD_W, default 3: destination register tag width.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  upstream result valid.
- in_ready  out  1  buffer can accept an entry this cycle.
- in_res  in  DATA_W  SRRes from the shift/rotate unit.
- in_flags  in  4  SRFlags, ordered {CF, ZF, SF, OF}.
- in_rd  in  RD_W  destination register tag.
- in_flag_we  in  1  entry updates architectural flags on retire.
- flush  in  1  discard buffered entries.
- out_valid  out  1  head entry valid.
- out_ready  in  1  writeback accepts the head entry.
- out_res  out  DATA_W  head result.
- out_rd  out  RD_W  head tag.
- arch_flags  out  4  architectural {CF, ZF, SF, OF}.
- occupancy  out  2  entries held, 0 to 2.

## Operation
- Storage: 2-entry circular FIFO with registered head pointer, tail pointer and a 2-bit count. Each entry holds {res, flags, rd, flag_we}.
- Handshake definitions:
  - Push occurs on `in_valid & in_ready`.
  - Pop occurs on `out_valid & out_ready`.
- in_ready = (count != 2). It depends only on state; there is no combinational path from out_ready.
- out_valid = (count != 0). out_res and out_rd come from the head entry. They hold stable while `out_valid & ~out_ready`.
- Count update: push only adds 1; pop only subtracts 1; push and pop together leave count unchanged. Pointers wrap modulo 2.
- Full (count 2): in_ready = 0; in_valid is ignored.
- Empty (count 0): no pop can occur. The input is not bypassed to the output, so an entry pushed in cycle N is first visible in cycle N+1.
- Retire: on a pop whose entry has flag_we = 1, arch_flags is loaded with that entry's flags at the clock edge. If flag_we = 0, arch_flags holds its value.
- Flush: at the edge, count, head and tail are cleared to 0. Any push in the same cycle is dropped. A pop in the same cycle still retires, including its flag update, because writeback has already consumed it. Entries behind the head are lost and never update flags.
- Reset (rst_n = 0 at an edge): count, head and tail go to 0, and arch_flags goes to 4'b0000. Reset overrides flush and any handshake, including mid-stream reset. Entry storage is not cleared.

## Timing
- Latency: a push at edge N makes out_valid = 1 from cycle N+1. Minimum input-to-retire time is 1 cycle.
- Throughput: 1 entry/cycle sustained when out_ready is held high. in_ready never drops while count stays at most 1.
- Backpressure: after out_ready goes low, the buffer absorbs 2 entries. in_ready falls in the cycle after the second push.
- arch_flags changes at the edge of the retiring pop. It is visible in the following cycle.
- Output values during reset and immediately after it:

  | Signal | Value |
  |---|---|
  | in_ready | 1 |
  | out_valid | 0 |
  | occupancy | 0 |
  | arch_flags | 0 |
  | out_res, out_rd | undefined while out_valid = 0 |

## Test plan
- **Reset:** hold rst_n = 0 for 2 cycles with in_valid = 1 → out_valid = 0, in_ready = 1, occupancy = 0, arch_flags = 4'b0000.
- **Streaming:** push res 0x40 / flags 4'b0000 / rd 3 / we 1, then res 0x00 / flags 4'b1100 / rd 5 / we 1, with out_ready = 1 → writeback sees (0x40, 3) then (0x00, 5). arch_flags = 4'b0000, then 4'b1100 one cycle after the second retire.
- **Backpressure:** hold out_ready = 0 and offer 3 entries (0x11, 0x22, 0x33) → occupancy reaches 2, in_ready = 0, and 0x33 is held upstream. Release out_ready → outputs 0x11, 0x22, 0x33 in order with no loss or duplication.
- **flag_we masking:** retire an entry with flags 4'b0010 / we 1, then one with flags 4'b1111 / we 0 → arch_flags stays 4'b0010.
- **Flush:** with 2 entries buffered (0xA0 head with flags 4'b1000 / we 1, then 0xB0 with flags 4'b0100 / we 1), assert flush, out_ready and in_valid (0xC0) in the same cycle → 0xA0 retires and arch_flags = 4'b1000. Next cycle: occupancy = 0, out_valid = 0; 0xB0 and 0xC0 never appear.
- **Mid-stream reset:** with occupancy 2 and arch_flags = 4'b0001, pull rst_n low for 1 cycle → occupancy = 0, arch_flags = 0, and no stale entry is presented afterwards.
